// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared types and response constants for the AHB-to-APB bridge front-end
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/ahb_slave_if_param_if.sv
// rtl/ahb_slave_if_param_if.sv - AHB-Lite slave side bus bundle with master/slave modports
interface ahb_slave_if_param_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3
);
    logic               Hwrite;
    logic               Hreadyin;
    logic [1:0]         Htrans;
    logic [2:0]         Hsize;
    logic [ADDR_W-1:0]  Haddr;
    logic [DATA_W-1:0]  Hwdata;
    logic [DATA_W-1:0]  Prdata;
    logic               valid;
    logic [ADDR_W-1:0]  Haddr1;
    logic [ADDR_W-1:0]  Haddr2;
    logic [DATA_W-1:0]  Hwdata1;
    logic [DATA_W-1:0]  Hwdata2;
    logic               Hwritereg;
    logic [NUM_SLV-1:0] tempselx;
    logic               Hreadyout;
    logic [1:0]         Hresp;
    logic [DATA_W-1:0]  Hrdata;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, Hreadyout, Hresp, Hrdata
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Hsize, Haddr, Hwdata, Prdata,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_slot_decode.sv
// rtl/ahb_slot_decode.sv - combinational decode of NUM_SLV equal power-of-two APB slots
module ahb_slot_decode
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] SLOT_SIZE = ADDR_W'(32'h0400_0000)
) (
    input  logic [ADDR_W-1:0]  haddr_i,
    output logic               hit_o,
    output logic [NUM_SLV-1:0] tempselx_o
);
    localparam int SHIFT = $clog2(SLOT_SIZE);
    localparam int EW    = ADDR_W + 5;

    // End of the decoded window is computed wide, then clipped to the top of the address space.
    localparam logic [EW-1:0]     TOP_EXT = EW'(1) << ADDR_W;
    localparam logic [EW-1:0]     END_RAW = EW'(BASE_ADDR) + EW'(NUM_SLV) * EW'(SLOT_SIZE);
    localparam logic [EW-1:0]     END_CLP = (END_RAW > TOP_EXT) ? TOP_EXT : END_RAW;
    localparam logic [ADDR_W:0]   END_A   = END_CLP[ADDR_W:0];
    localparam logic [ADDR_W:0]   BASE_A  = {1'b0, BASE_ADDR};

    logic [ADDR_W:0]   addr_a;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] slot_idx;

    assign addr_a   = {1'b0, haddr_i};
    assign offset   = haddr_i - BASE_ADDR;
    assign slot_idx = offset >> SHIFT;
    assign hit_o    = (addr_a >= BASE_A) && (addr_a < END_A);

    always_comb begin
        tempselx_o = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            tempselx_o[i] = hit_o && (slot_idx == ADDR_W'(i));
        end
    end
endmodule

// File: rtl/ahb_slave_if_param.sv
// rtl/ahb_slave_if_param.sv - AHB-Lite slave front-end: slot decode, pipeline, two-cycle ERROR FSM
// Optional: AHB_ALIGN_CHECK_EN adds alignment/size qualification of hits.
module ahb_slave_if_param
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] SLOT_SIZE = ADDR_W'(32'h0400_0000)
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    ahb_slave_if_param_if.slave  bus
);
    logic               xfer;
    logic               addr_hit;
    logic               hit;
    logic [NUM_SLV-1:0] sel_raw;
    err_state_e         state_q, state_d;
    logic [1:0]         hresp;
    logic               hreadyout;
    logic [ADDR_W-1:0]  haddr1_q, haddr2_q;
    logic [DATA_W-1:0]  hwdata1_q, hwdata2_q;
    logic               hwritereg_q;

    ahb_slot_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_SIZE (SLOT_SIZE)
    ) u_decode (
        .haddr_i    (bus.Haddr),
        .hit_o      (addr_hit),
        .tempselx_o (sel_raw)
    );

`ifdef AHB_ALIGN_CHECK_EN
    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    logic [ADDR_W-1:0] align_mask;
    logic              aligned;
    assign align_mask = ~({ADDR_W{1'b1}} << bus.Hsize);
    assign aligned    = ((bus.Haddr & align_mask) == '0) && (bus.Hsize <= 3'(MAX_SIZE));
    assign hit        = addr_hit & aligned;
`else
    logic unused_hsize;
    assign unused_hsize = ^bus.Hsize;
    assign hit          = addr_hit;
`endif

    assign xfer         = bus.Hreadyin & bus.Htrans[1];
    // ERR1 is the stalled error cycle; anything on the bus then is not a real transfer.
    assign bus.valid    = Hresetn & xfer & hit & (state_q != ST_ERR1);
    assign bus.tempselx = (Hresetn & hit) ? sel_raw : '0;
    assign bus.Hrdata   = bus.Prdata;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            haddr1_q    <= '0;
            haddr2_q    <= '0;
            hwdata1_q   <= '0;
            hwdata2_q   <= '0;
            hwritereg_q <= 1'b0;
        end else if (bus.Hreadyin) begin
            haddr1_q    <= bus.Haddr;
            haddr2_q    <= haddr1_q;
            hwdata1_q   <= bus.Hwdata;
            hwdata2_q   <= hwdata1_q;
            hwritereg_q <= bus.Hwrite;
        end
    end

    assign bus.Haddr1    = haddr1_q;
    assign bus.Haddr2    = haddr2_q;
    assign bus.Hwdata1   = hwdata1_q;
    assign bus.Hwdata2   = hwdata2_q;
    assign bus.Hwritereg = hwritereg_q;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        hresp     = HRESP_OKAY;
        hreadyout = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (xfer && !hit) state_d = ST_ERR1;
            end
            ST_ERR1: begin
                hresp     = HRESP_ERROR;
                hreadyout = 1'b0;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = (xfer && !hit) ? ST_ERR1 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Hresp     = hresp;
    assign bus.Hreadyout = hreadyout;
endmodule

// File: tb/tb_ahb_slave_if_param.sv
// tb/tb_ahb_slave_if_param.sv - directed self-checking bench for ahb_slave_if_param
module tb_ahb_slave_if_param;
    logic Hclk;
    logic Hresetn;
    int   checks;
    int   errors;

    ahb_slave_if_param_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bus ();
    ahb_slave_if_param_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(8)) bus8 ();

    ahb_slave_if_param #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3),
        .BASE_ADDR(32'h8000_0000), .SLOT_SIZE(32'h0400_0000)
    ) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    ahb_slave_if_param #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(8),
        .BASE_ADDR(32'h8000_0000), .SLOT_SIZE(32'h0010_0000)
    ) dut8 (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus8)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] trans, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic wr);
        bus.Htrans = trans;
        bus.Haddr  = addr;
        bus.Hwdata = wdata;
        bus.Hwrite = wr;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Hresetn = 1'b0;
        bus.Hreadyin = 1'b1;
        bus.Hsize    = 3'b010;
        bus.Prdata   = 32'h1234_5678;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        bus8.Hreadyin = 1'b1;
        bus8.Htrans   = 2'b00;
        bus8.Hsize    = 3'b010;
        bus8.Haddr    = 32'h0;
        bus8.Hwdata   = 32'h0;
        bus8.Hwrite   = 1'b0;
        bus8.Prdata   = 32'h0;
        #1;

        chk("rst_hresp", 64'(bus.Hresp), 64'h0);
        chk("rst_hreadyout", 64'(bus.Hreadyout), 64'h1);
        chk("rst_haddr1", 64'(bus.Haddr1), 64'h0);
        chk("rst_valid", 64'(bus.valid), 64'h0);

        tick();
        Hresetn = 1'b1;
        drive(2'b10, 32'h8400_0004, 32'h0000_00A1, 1'b1);
        #1;
        chk("dec_slot1_sel", 64'(bus.tempselx), 64'h2);
        chk("dec_slot1_valid", 64'(bus.valid), 64'h1);
        chk("hrdata", 64'(bus.Hrdata), 64'h1234_5678);
        drive(2'b10, 32'h8BFF_FFFC, 32'h0, 1'b0);
        #1;
        chk("dec_slot2_sel", 64'(bus.tempselx), 64'h4);
        drive(2'b10, 32'h8000_0000, 32'h0, 1'b0);
        #1;
        chk("dec_slot0_sel", 64'(bus.tempselx), 64'h1);
        drive(2'b00, 32'h7FFF_FFFC, 32'h0, 1'b0);
        #1;
        chk("dec_below_sel", 64'(bus.tempselx), 64'h0);
        chk("idle_no_valid", 64'(bus.valid), 64'h0);
        drive(2'b01, 32'h8000_0000, 32'h0, 1'b0);
        #1;
        chk("busy_no_valid", 64'(bus.valid), 64'h0);
        tick();

        // Unmapped NONSEQ: ERR1, ERR2, then OKAY
        drive(2'b10, 32'h8C00_0000, 32'h0, 1'b0);
        #1;
        chk("unm_sel", 64'(bus.tempselx), 64'h0);
        chk("unm_valid0", 64'(bus.valid), 64'h0);
        chk("unm_resp0", 64'(bus.Hresp), 64'h0);
        tick();
        chk("err1_resp", 64'(bus.Hresp), 64'h1);
        chk("err1_ready", 64'(bus.Hreadyout), 64'h0);
        chk("err1_valid", 64'(bus.valid), 64'h0);
        drive(2'b00, 32'h8C00_0000, 32'h0, 1'b0);
        tick();
        chk("err2_resp", 64'(bus.Hresp), 64'h1);
        chk("err2_ready", 64'(bus.Hreadyout), 64'h1);
        chk("err2_valid", 64'(bus.valid), 64'h0);
        tick();
        chk("post_err_resp", 64'(bus.Hresp), 64'h0);
        chk("post_err_ready", 64'(bus.Hreadyout), 64'h1);

        // Stall: pipeline holds while Hreadyin=0
        drive(2'b10, 32'h8000_0010, 32'h0000_0011, 1'b1);
        tick();
        drive(2'b10, 32'h8000_0020, 32'h0000_0022, 1'b0);
        tick();
        bus.Hreadyin = 1'b0;
        drive(2'b10, 32'h8000_0030, 32'h0000_0033, 1'b1);
        tick();
        drive(2'b10, 32'h8000_0040, 32'h0000_0044, 1'b1);
        tick();
        drive(2'b10, 32'h8000_0050, 32'h0000_0055, 1'b1);
        tick();
        chk("stall_haddr1", 64'(bus.Haddr1), 64'h8000_0020);
        chk("stall_haddr2", 64'(bus.Haddr2), 64'h8000_0010);
        chk("stall_hwdata1", 64'(bus.Hwdata1), 64'h22);
        chk("stall_hwdata2", 64'(bus.Hwdata2), 64'h11);
        chk("stall_hwritereg", 64'(bus.Hwritereg), 64'h0);
        chk("stall_resp", 64'(bus.Hresp), 64'h0);
        bus.Hreadyin = 1'b1;
        drive(2'b10, 32'h8000_0060, 32'h0000_0066, 1'b1);
        tick();
        chk("adv_haddr1", 64'(bus.Haddr1), 64'h8000_0060);
        chk("adv_haddr2", 64'(bus.Haddr2), 64'h8000_0020);
        chk("adv_hwdata1", 64'(bus.Hwdata1), 64'h66);
        chk("adv_hwdata2", 64'(bus.Hwdata2), 64'h22);
        chk("adv_hwritereg", 64'(bus.Hwritereg), 64'h1);

        // Back-to-back errors
        drive(2'b10, 32'h9000_0000, 32'h0, 1'b0);
        tick();
        drive(2'b00, 32'h9000_0000, 32'h0, 1'b0);
        tick();
        drive(2'b10, 32'hA000_0000, 32'h0, 1'b0);
        #1;
        chk("b2b_err2_resp", 64'(bus.Hresp), 64'h1);
        chk("b2b_err2_valid", 64'(bus.valid), 64'h0);
        tick();
        chk("b2b_err1_resp", 64'(bus.Hresp), 64'h1);
        chk("b2b_err1_ready", 64'(bus.Hreadyout), 64'h0);
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        drive(2'b11, 32'h8000_0100, 32'h0, 1'b0);
        #1;
        chk("seq_in_err2_valid", 64'(bus.valid), 64'h1);
        chk("seq_in_err2_sel", 64'(bus.tempselx), 64'h1);
        tick();
        chk("seq_back_idle_resp", 64'(bus.Hresp), 64'h0);
        chk("seq_back_idle_ready", 64'(bus.Hreadyout), 64'h1);

        // Reset asserted in ERR1
        drive(2'b10, 32'h9000_0000, 32'h0, 1'b0);
        tick();
        drive(2'b10, 32'h8400_0004, 32'h0, 1'b0);
        #1;
        chk("pre_rst_err1_resp", 64'(bus.Hresp), 64'h1);
        chk("err1_ignores_valid", 64'(bus.valid), 64'h0);
        Hresetn = 1'b0;
        #1;
        chk("rst_err1_resp", 64'(bus.Hresp), 64'h0);
        chk("rst_err1_ready", 64'(bus.Hreadyout), 64'h1);
        chk("rst_err1_haddr1", 64'(bus.Haddr1), 64'h0);
        chk("rst_err1_haddr2", 64'(bus.Haddr2), 64'h0);
        chk("rst_err1_valid", 64'(bus.valid), 64'h0);
        chk("rst_err1_sel", 64'(bus.tempselx), 64'h0);
        tick();
        Hresetn = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        tick();

        // Alignment / size qualification
        bus.Hsize = 3'b010;
        drive(2'b10, 32'h8000_0002, 32'h0, 1'b0);
        #1;
`ifdef AHB_ALIGN_CHECK_EN
        chk("misalign_valid", 64'(bus.valid), 64'h0);
        tick();
        chk("misalign_err1_resp", 64'(bus.Hresp), 64'h1);
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        chk("misalign_done_resp", 64'(bus.Hresp), 64'h0);
        bus.Hsize = 3'b011;
        drive(2'b10, 32'h8000_0000, 32'h0, 1'b0);
        #1;
        chk("oversize_valid", 64'(bus.valid), 64'h0);
        tick();
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        bus.Hsize = 3'b001;
        drive(2'b10, 32'h8000_0002, 32'h0, 1'b0);
        #1;
        chk("half_align_valid", 64'(bus.valid), 64'h1);
        chk("half_align_sel", 64'(bus.tempselx), 64'h1);
`else
        chk("noalign_valid", 64'(bus.valid), 64'h1);
        chk("noalign_sel", 64'(bus.tempselx), 64'h1);
`endif
        drive(2'b00, 32'h0, 32'h0, 1'b0);
        tick();

        // Eight 1 MiB slots
        bus8.Htrans = 2'b10;
        bus8.Haddr  = 32'h8070_0000;
        #1;
        chk("p8_slot7_sel", 64'(bus8.tempselx), 64'h80);
        chk("p8_slot7_valid", 64'(bus8.valid), 64'h1);
        bus8.Haddr  = 32'h8080_0000;
        #1;
        chk("p8_end_sel", 64'(bus8.tempselx), 64'h0);
        chk("p8_end_valid", 64'(bus8.valid), 64'h0);
        tick();
        chk("p8_end_err1_resp", 64'(bus8.Hresp), 64'h1);
        chk("p8_end_err1_ready", 64'(bus8.Hreadyout), 64'h0);
        bus8.Htrans = 2'b00;
        tick();
        tick();
        chk("p8_done_resp", 64'(bus8.Hresp), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
